// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: write-only driver for an HD44780-style 8-bit character LCD.
// After reset it waits INIT_WAIT cycles, sends the four-command init sequence and then
// writes one full frame (upper line: 2 digits, lower line: 4 digits) per rising edge of
// valid_in. Rising edges seen while not idle collapse into a single pending request.
//
// Ports:
//   clock                     system clock, rising edge
//   reset                     asynchronous reset, active low
//   valid_in                  level flag; each 0->1 edge requests one frame
//   upper10, upper01          upper-line ASCII digits, tens then units
//   lower1000 .. lower0001    lower-line ASCII digits, MSD first
//   lcd_data, lcd_rs, lcd_e   LCD bus (rs: 0 = command, 1 = character)
//   lcd_rw                    tied low, the LCD is never read
//   init_done                 high once the init sequence has completed
//   busy                      high while a frame is being written
//   frame_done                one-cycle pulse at the end of a frame
module lcd_frame_writer #(
   parameter int unsigned E_CYCLES   = 4,
   parameter int unsigned CMD_WAIT   = 50,
   parameter int unsigned CLEAR_WAIT = 2000,
   parameter int unsigned INIT_WAIT  = 20000,
   parameter logic [6:0]  UPPER_ADDR = 7'h00,
   parameter logic [6:0]  LOWER_ADDR = 7'h40
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [7:0] upper10,
   input  logic [7:0] upper01,
   input  logic [7:0] lower1000,
   input  logic [7:0] lower0100,
   input  logic [7:0] lower0010,
   input  logic [7:0] lower0001,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic       init_done,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned MaxA   = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
   localparam int unsigned MaxB   = (CMD_WAIT > E_CYCLES) ? CMD_WAIT : E_CYCLES;
   localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   typedef enum logic [2:0] {StInitWait, StSetup, StEHigh, StWait, StIdle} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic [2:0]       idx_q;      // byte index within the current sequence
   logic             frame_q;    // 0: init sequence, 1: frame
   logic             pending_q;
   logic             valid_q;
   logic [5:0][7:0]  buf_q;      // frame snapshot, [0] = upper10 .. [5] = lower0001

   logic             valid_rise;
   logic [CntW-1:0]  wait_last;
   logic             last_byte;
   logic [2:0]       idx_nxt;
   logic [7:0]       nxt_data;
   logic             nxt_rs;

   assign lcd_rw     = 1'b0;
   assign valid_rise = valid_in & ~valid_q;
   assign idx_nxt    = idx_q + 3'd1;
   assign last_byte  = frame_q ? (idx_q == 3'd7) : (idx_q == 3'd3);
   // Clear Display (third init command) needs the long wait.
   assign wait_last  = (!frame_q && idx_q == 3'd2) ? CntW'(CLEAR_WAIT - 1) :
                                                     CntW'(CMD_WAIT - 1);

   // Byte and register select for the transfer following the current one.
   always_comb begin
      nxt_rs   = 1'b0;
      nxt_data = 8'h00;
      if (frame_q) begin
         unique case (idx_nxt)
            3'd0: nxt_data = {1'b1, UPPER_ADDR};
            3'd1: begin nxt_rs = 1'b1; nxt_data = buf_q[0]; end
            3'd2: begin nxt_rs = 1'b1; nxt_data = buf_q[1]; end
            3'd3: nxt_data = {1'b1, LOWER_ADDR};
            3'd4: begin nxt_rs = 1'b1; nxt_data = buf_q[2]; end
            3'd5: begin nxt_rs = 1'b1; nxt_data = buf_q[3]; end
            3'd6: begin nxt_rs = 1'b1; nxt_data = buf_q[4]; end
            3'd7: begin nxt_rs = 1'b1; nxt_data = buf_q[5]; end
         endcase
      end else begin
         unique case (idx_nxt[1:0])
            2'd0: nxt_data = 8'h38;
            2'd1: nxt_data = 8'h0C;
            2'd2: nxt_data = 8'h01;
            2'd3: nxt_data = 8'h06;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StInitWait;
         cnt_q      <= '0;
         idx_q      <= '0;
         frame_q    <= 1'b0;
         pending_q  <= 1'b0;
         valid_q    <= 1'b0;
         buf_q      <= '0;
         lcd_data   <= '0;
         lcd_rs     <= 1'b0;
         lcd_e      <= 1'b0;
         init_done  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_q    <= valid_in;
         frame_done <= 1'b0;
         // In IDLE an edge starts a frame directly; elsewhere it is remembered.
         if (valid_rise && state_q != StIdle) pending_q <= 1'b1;

         unique case (state_q)
            StInitWait: begin
               if (cnt_q == CntW'(INIT_WAIT - 1)) begin
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  frame_q  <= 1'b0;
                  lcd_data <= 8'h38;
                  lcd_rs   <= 1'b0;
                  state_q  <= StSetup;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StSetup: begin
               cnt_q   <= '0;
               lcd_e   <= 1'b1;
               state_q <= StEHigh;
            end
            StEHigh: begin
               if (cnt_q == CntW'(E_CYCLES - 1)) begin
                  cnt_q   <= '0;
                  lcd_e   <= 1'b0;
                  state_q <= StWait;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWait: begin
               if (cnt_q == wait_last) begin
                  cnt_q <= '0;
                  if (last_byte) begin
                     state_q <= StIdle;
                     if (frame_q) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                     end else begin
                        init_done <= 1'b1;
                     end
                  end else begin
                     idx_q    <= idx_nxt;
                     lcd_data <= nxt_data;
                     lcd_rs   <= nxt_rs;
                     state_q  <= StSetup;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StIdle: begin
               if (valid_rise || pending_q) begin
                  buf_q     <= {lower0001, lower0010, lower0100, lower1000, upper01, upper10};
                  busy      <= 1'b1;
                  pending_q <= 1'b0;
                  frame_q   <= 1'b1;
                  idx_q     <= '0;
                  cnt_q     <= '0;
                  lcd_data  <= {1'b1, UPPER_ADDR};
                  lcd_rs    <= 1'b0;
                  state_q   <= StSetup;
               end
            end
            default: state_q <= StInitWait;
         endcase
      end
   end

endmodule
